// File: rtl/dmem_responder_pkg.sv
// Shared data-memory bus definitions: command codes and the response-slot record
// reused by the responder and by bus monitors.
package dmem_responder_pkg;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, one port of each.
module dmem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [31:0]              rdata
);

    // Zero power-up contents; reset deliberately leaves the array alone.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the data-memory bus: decodes one command per cycle, commits stores,
// and returns load data through a LATENCY-deep registered response pipeline.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2mem_data,
    output logic [31:0] mem2proc_data,
    output logic        mem2proc_valid,
    output logic        mem2proc_err,
    output logic [31:0] load_count,
    output logic [31:0] store_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic [31:0]      offset;
    logic             legal;
    logic             is_load;
    logic             is_store;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rdata;
    dmem_resp_t       slot_in;
    dmem_resp_t       pipe_q [LATENCY];
    logic [31:0]      load_cnt_q;
    logic [31:0]      store_cnt_q;

    // Range test on the offset avoids overflow of BASE_ADDR + span near the top of memory.
    always_comb begin
        offset   = proc2Dmem_addr - BASE_ADDR;
        legal    = (proc2Dmem_command == BUS_LOAD || proc2Dmem_command == BUS_STORE)
                   && (proc2Dmem_addr[1:0] == 2'b00)
                   && (proc2Dmem_addr >= BASE_ADDR)
                   && (offset < SPAN);
        is_load  = legal && (proc2Dmem_command == BUS_LOAD);
        is_store = legal && (proc2Dmem_command == BUS_STORE);
        idx      = offset[IDX_W+1:2];

        slot_in       = '0;
        slot_in.valid = is_load;
        slot_in.err   = !legal && (proc2Dmem_command != BUS_NONE);
        slot_in.data  = is_load ? rdata : 32'h0;
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (is_store && !rst),
        .widx  (idx),
        .wdata (proc2mem_data),
        .ridx  (idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            pipe_q[0] <= slot_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (is_load && load_cnt_q != 32'hFFFF_FFFF) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (is_store && store_cnt_q != 32'hFFFF_FFFF) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
        end
    end

    assign mem2proc_valid = pipe_q[LATENCY-1].valid;
    assign mem2proc_err   = pipe_q[LATENCY-1].err;
    assign mem2proc_data  = pipe_q[LATENCY-1].data;
    assign load_count     = load_cnt_q;
    assign store_count    = store_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a reference memory model pushes expected response slots
// into a scoreboard queue; a negedge monitor pops and compares them against the outputs.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    typedef struct {
        int         tgt;
        dmem_resp_t r;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [1:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic [31:0] lcnt;
    logic [31:0] scnt;

    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    bit          mon_en = 0;
    sb_entry_t   sb_q[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_lc;
    logic [31:0] mdl_sc;

    dmem_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .proc2Dmem_addr    (addr),
        .proc2Dmem_command (cmd),
        .proc2mem_data     (wdata),
        .mem2proc_data     (rd_data),
        .mem2proc_valid    (rd_valid),
        .mem2proc_err      (rd_err),
        .load_count        (lcnt),
        .store_count       (scnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slots with no scoreboard entry must be idle: valid=0, err=0, data=0.
    always @(negedge clk) begin
        dmem_resp_t exp;
        ncyc++;
        if (mon_en) begin
            exp = '0;
            if (sb_q.size() > 0 && sb_q[0].tgt == ncyc) begin
                exp = sb_q.pop_front().r;
            end
            checks++;
            if ({rd_valid, rd_err, rd_data} !== exp) begin
                errors++;
                $display("FAIL resp cyc=%0d got v=%0b e=%0b d=%08h want v=%0b e=%0b d=%08h",
                         ncyc, rd_valid, rd_err, rd_data, exp.valid, exp.err, exp.data);
            end
        end
    end

    function automatic bit model_legal(input logic [1:0] c, input logic [31:0] a);
        longint unsigned lo, hi;
        lo = longint'(BASE);
        hi = longint'(BASE) + longint'(DEPTH) * 4;
        return (c == 2'd1 || c == 2'd2) && (a % 4 == 0) && (longint'(a) >= lo)
               && (longint'(a) < hi);
    endfunction

    // Drive one request for one cycle, predicting its response slot.
    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        sb_entry_t e;
        int        wi;
        cmd   = c;
        addr  = a;
        wdata = d;
        e.tgt = ncyc + LAT;
        e.r   = '0;
        wi    = int'((a - BASE) / 4) % DEPTH;
        if (model_legal(c, a) && c == 2'd1) begin
            e.r.valid = 1'b1;
            e.r.data  = mdl_mem[wi];
            if (mdl_lc != 32'hFFFF_FFFF) mdl_lc++;
        end else if (model_legal(c, a)) begin
            mdl_mem[wi] = d;
            if (mdl_sc != 32'hFFFF_FFFF) mdl_sc++;
        end else if (c != 2'd0) begin
            e.r.err = 1'b1;
        end
        if (e.r.valid || e.r.err) sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(BUS_NONE, 32'h0, 32'h0);
    endtask

    // A request accompanies the reset cycle and must be ignored.
    task automatic pulse_reset();
        rst   = 1'b1;
        cmd   = BUS_STORE;
        addr  = BASE + 32'h20;
        wdata = 32'h5555_AAAA;
        sb_q.delete();
        mdl_lc = '0;
        mdl_sc = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        cmd = BUS_NONE;
    endtask

    task automatic test_reset();
        checks++;
        if ({rd_valid, rd_err, rd_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_resp got v=%0b e=%0b d=%08h want 0", rd_valid, rd_err, rd_data);
        end
        checks++;
        if (lcnt !== 32'h0 || scnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts got l=%08h s=%08h want 0", lcnt, scnt);
        end
    endtask

    task automatic test_basic();
        drive(BUS_STORE, BASE + 32'h10, 32'hCAFE_F00D);
        drive(BUS_LOAD, BASE + 32'h10, 32'h0);
        idle(LAT);
        checks++;
        if (scnt !== 32'd1 || lcnt !== 32'd1) begin
            errors++;
            $display("FAIL basic_counts got s=%0d l=%0d want s=1 l=1", scnt, lcnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(BUS_STORE, BASE + 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) drive(BUS_LOAD, BASE + 32'(4 * i), 32'h0);
        idle(LAT);
        checks++;
        if (lcnt !== mdl_lc || scnt !== mdl_sc) begin
            errors++;
            $display("FAIL b2b_counts got l=%0d s=%0d want l=%0d s=%0d", lcnt, scnt, mdl_lc, mdl_sc);
        end
    endtask

    task automatic test_errors();
        logic [31:0] sc_before;
        sc_before = scnt;
        drive(BUS_LOAD, BASE + 32'h6, 32'h0);
        drive(BUS_STORE, BASE + 32'(DEPTH * 4), 32'hDEAD_BEEF);
        drive(BUS_LOAD, BASE, 32'h0);
        drive(2'd3, BASE + 32'h8, 32'h1234_5678);
        drive(BUS_STORE, BASE - 32'h4, 32'hBAD0_BAD0);
        drive(BUS_LOAD, BASE - 32'h4, 32'h0);
        idle(LAT);
        checks++;
        if (scnt !== sc_before) begin
            errors++;
            $display("FAIL err_store_count got %0d want %0d", scnt, sc_before);
        end
        checks++;
        if (lcnt !== mdl_lc) begin
            errors++;
            $display("FAIL err_load_count got %0d want %0d", lcnt, mdl_lc);
        end
    endtask

    task automatic test_reset_midflight();
        drive(BUS_STORE, BASE + 32'h20, 32'hABCD_1234);
        drive(BUS_LOAD, BASE + 32'h20, 32'h0);
        drive(BUS_LOAD, BASE + 32'h24, 32'h0);
        pulse_reset();
        checks++;
        if (lcnt !== 32'h0 || scnt !== 32'h0) begin
            errors++;
            $display("FAIL midflight_counts got l=%0d s=%0d want 0", lcnt, scnt);
        end
        idle(LAT + 1);
        drive(BUS_LOAD, BASE + 32'h20, 32'h0);
        idle(LAT);
        checks++;
        if (lcnt !== 32'd1) begin
            errors++;
            $display("FAIL midflight_reload_count got %0d want 1", lcnt);
        end
    endtask

    task automatic test_bubbles_raw();
        for (int k = 1; k <= 8; k++) begin
            drive(BUS_STORE, BASE + 32'h80 + 32'(4 * k), 32'(k));
            drive(BUS_LOAD, BASE + 32'h80 + 32'(4 * k), 32'h0);
            drive(BUS_NONE, 32'h0, 32'h0);
        end
        idle(LAT);
        checks++;
        if (lcnt !== mdl_lc || scnt !== mdl_sc) begin
            errors++;
            $display("FAIL raw_counts got l=%0d s=%0d want l=%0d s=%0d", lcnt, scnt, mdl_lc, mdl_sc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, DEPTH + 3) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'd2;
            drive(2'($urandom_range(0, 3)), a, $urandom);
        end
        idle(LAT);
        checks++;
        if (lcnt !== mdl_lc || scnt !== mdl_sc) begin
            errors++;
            $display("FAIL rand_counts got l=%0d s=%0d want l=%0d s=%0d", lcnt, scnt, mdl_lc, mdl_sc);
        end
    endtask

    task automatic test_saturation();
        force dut.load_cnt_q = 32'hFFFF_FFFE;
        mdl_lc = 32'hFFFF_FFFE;
        drive(BUS_NONE, 32'h0, 32'h0);
        release dut.load_cnt_q;
        for (int i = 0; i < 3; i++) begin
            drive(BUS_LOAD, BASE + 32'(4 * i), 32'h0);
            checks++;
            if (lcnt !== mdl_lc) begin
                errors++;
                $display("FAIL sat_load_count step=%0d got %08h want %08h", i, lcnt, mdl_lc);
            end
        end
        idle(LAT);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
        mdl_lc = '0;
        mdl_sc = '0;
        rst    = 1'b1;
        cmd    = BUS_NONE;
        addr   = '0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        #1;
        mon_en = 1'b1;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_back_to_back();
        test_errors();
        test_reset_midflight();
        test_bubbles_raw();
        test_random();
        test_saturation();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
